etch_cursor_plotter: RTL and testbench
======================================

Name: etch_cursor_plotter

Overview:
- Sits directly downstream of the two per-axis quadrature decoders.
- Consumes their free-running 8-bit wrapping position counts and converts count changes into a clamped on-screen cursor position.
- Issues one-pixel "ink" writes to the framebuffer write port over a valid/ready handshake.
- Also performs the full-screen clear sweep, at power-up and on request.

Parameters:
- H_RES, 160, horizontal resolution in pixels.
- V_RES, 120, vertical resolution in pixels.
- COUNT_W, 8, width of incoming decoder counts.
- X_W, 8, cursor X width; must satisfy 2^X_W >= H_RES.
- Y_W, 7, cursor Y width; must satisfy 2^Y_W >= V_RES.
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- x_count  in  COUNT_W  X-axis decoder count, synchronous to clk, wraps modulo 2^COUNT_W.
- y_count  in  COUNT_W  Y-axis decoder count, same rules as x_count.
- clear_req  in  1  single-cycle pulse requesting a screen clear.
- wr_valid  out  1  framebuffer write request.
- wr_ready  in  1  framebuffer accepts the write when wr_valid&wr_ready.
- wr_addr  out  ADDR_W  pixel address = y*H_RES + x.
- wr_data  out  1  pixel value (1 = ink, 0 = blank).
- cursor_x  out  X_W  current cursor X.
- cursor_y  out  Y_W  current cursor Y.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=CLEAR, clr_addr=0.
  - cursor_x=H_RES/2 (80), cursor_y=V_RES/2 (60).
  - wr_valid=0, wr_addr=0, wr_data=0, busy=1, clr_pend=0.
  - prev_x=0, prev_y=0.
- States: CLEAR, PLOT, IDLE. All outputs are registered.
- CLEAR:
  - First cycle after reset release: wr_valid=1, wr_data=0, wr_addr=clr_addr.
  - On each handshake, clr_addr increments.
  - On the handshake at address H_RES*V_RES-1: load prev_x<=x_count and prev_y<=y_count, then go to PLOT.
  - Consequence: motion during the clear is discarded, and the cursor does not move.
- PLOT:
  - wr_valid=1, wr_data=1, wr_addr=cursor_y*H_RES+cursor_x.
  - wr_addr and wr_data stay stable while wr_valid=1 and wr_ready=0.
  - On handshake: if clr_pend, clear it and go to CLEAR with clr_addr=0; else go to IDLE.
- IDLE (wr_valid=0, busy=0). Each cycle:
  - Compute dx=x_count-prev_x and dy=y_count-prev_y, both modulo 2^COUNT_W, interpreted as signed (-128..+127).
  - If clear_req=1: go to CLEAR. This takes priority over motion; prev_x/prev_y are not updated, and the motion is discarded as above.
  - Else if dx!=0 or dy!=0:
    - Load prev_x<=x_count, prev_y<=y_count.
    - Update cursor_x<=clamp(cursor_x+dx, 0, H_RES-1) and cursor_y<=clamp(cursor_y+dy, 0, V_RES-1), computed in signed X_W+2 / Y_W+2 bits.
    - Go to PLOT.
  - Latency: a count change seen in IDLE at cycle N gives the updated cursor and wr_valid=1 at N+1.
- clear_req outside IDLE:
  - In PLOT: sets clr_pend; the clear runs after the current write.
  - In CLEAR: ignored; the sweep is not restarted.
- Counter wrap: an x_count step 255->0 is dx=+1; 0->255 is dx=-1.
- Accumulated motion while in PLOT: whole net delta applied at the next IDLE. Net |delta|>127 aliases; this is acceptable because the decoders move at most 1 count per cycle and a PLOT stall of more than 127 cycles is out of spec.
- Clamping: a cursor at an edge stays at the edge. It still re-plots the same pixel whenever the delta is nonzero.
- Reset mid-operation: immediate return to the reset values; any in-flight handshake is abandoned.

Decomposition:
- Shared package etch_pkg holds:
  - H_RES, V_RES and derived ADDR_W.
  - State encoding constants CLEAR/PLOT/IDLE.
  - Centre-position constants.
- Natural sub-module: etch_clamp_add. It is combinational: signed delta plus unsigned position, saturated to [0, LIMIT-1]. It is instantiated once per axis.

Test Plan:
- Reset release with wr_ready=1 throughout -> 19200 writes, wr_data=0, addresses 0..19199 in order; then one write with addr=60*160+80=9680, data=1; then busy=0.
- In IDLE, x_count 0->1 -> next cycle cursor_x=81, wr_valid=1, wr_addr=9681, wr_data=1.
- x_count 0->255 (one step) -> cursor_x=79, wr_addr=9679.
- Cursor at x=159, dx=+5 -> cursor_x stays 159, write at addr 60*160+159=9759.
- Hold wr_ready=0 for 10 cycles in PLOT while y_count advances +3 -> wr_addr/wr_data stable; after the handshake, IDLE applies dy=+3 (cursor_y 60->63), next write at addr 63*160+80=10160.
- Pulse clear_req during a stalled PLOT -> after that handshake, CLEAR starts at addr 0 with data 0; busy stays 1 until the post-clear cursor plot is accepted.

Source files
------------

// File: rtl/etch_pkg.sv
// Shared constants, state encoding and pixel-address helper for the
// etch cursor plotter.
package etch_pkg;

  localparam int H_RES   = 160;
  localparam int V_RES   = 120;
  localparam int COUNT_W = 8;
  localparam int X_W     = 8;
  localparam int Y_W     = 7;
  localparam int NPIX    = H_RES * V_RES;
  localparam int ADDR_W  = $clog2(NPIX);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    PLOT  = 2'd1,
    IDLE  = 2'd2
  } state_t;

  localparam logic [X_W-1:0]    X_CENTRE  = X_W'(H_RES / 2);
  localparam logic [Y_W-1:0]    Y_CENTRE  = Y_W'(V_RES / 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/etch_cursor_plotter_if.sv
// Framebuffer write port. A write transfers on any rising clk edge where
// wr_valid && wr_ready; while wr_valid is high and wr_ready low, wr_addr and
// wr_data hold steady and wr_valid is not withdrawn.
interface etch_cursor_plotter_if;
  import etch_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/etch_clamp_add.sv
// Signed delta added to an unsigned position, saturated to [0, LIMIT-1].
// Two guard bits keep the sum free of overflow before the clamp.
module etch_clamp_add #(
  parameter int W     = 8,
  parameter int DW    = 8,
  parameter int LIMIT = 160
) (
  input  logic [W-1:0]         pos,
  input  logic signed [DW-1:0] delta,
  output logic [W-1:0]         result
);

  localparam logic signed [W+1:0] MAX_POS = (W+2)'(LIMIT - 1);

  logic signed [W+1:0] sum;

  assign sum = $signed({2'b00, pos}) + $signed({{(W+2-DW){delta[DW-1]}}, delta});

  always_comb begin
    result = sum[W-1:0];
    if (sum < 0)
      result = '0;
    else if (sum > MAX_POS)
      result = MAX_POS[W-1:0];
  end

endmodule

// File: rtl/etch_cursor_plotter.sv
// Turns wrapping quadrature counts into a clamped cursor, inks one pixel per
// move, and sweeps the framebuffer blank after reset or on request.
module etch_cursor_plotter
  import etch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COUNT_W-1:0]    x_count,
  input  logic [COUNT_W-1:0]    y_count,
  input  logic                  clear_req,
  etch_cursor_plotter_if.master wr,
  output logic [X_W-1:0]        cursor_x,
  output logic [Y_W-1:0]        cursor_y,
  output logic                  busy,
  output state_t                state
);

  state_t              state_n;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_n;
  logic [COUNT_W-1:0]  prev_x, prev_x_n, prev_y, prev_y_n;
  logic [X_W-1:0]      cursor_x_n, nx_x;
  logic [Y_W-1:0]      cursor_y_n, nx_y;
  logic                wr_valid_q, wr_valid_n, wr_data_q, wr_data_n;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_n;
  logic                clr_pend, clr_pend_n, busy_n, hs;
  logic signed [COUNT_W-1:0] dx, dy;

  // Modular subtraction makes counter wrap look like a +/-1 step.
  assign dx = x_count - prev_x;
  assign dy = y_count - prev_y;
  assign hs = wr_valid_q & wr.wr_ready;

  etch_clamp_add #(.W(X_W), .DW(COUNT_W), .LIMIT(H_RES)) u_clamp_x (
    .pos(cursor_x), .delta(dx), .result(nx_x));
  etch_clamp_add #(.W(Y_W), .DW(COUNT_W), .LIMIT(V_RES)) u_clamp_y (
    .pos(cursor_y), .delta(dy), .result(nx_y));

  always_comb begin
    state_n    = state;
    clr_addr_n = clr_addr;
    prev_x_n   = prev_x;
    prev_y_n   = prev_y;
    cursor_x_n = cursor_x;
    cursor_y_n = cursor_y;
    wr_valid_n = wr_valid_q;
    wr_addr_n  = wr_addr_q;
    wr_data_n  = wr_data_q;
    clr_pend_n = clr_pend;
    case (state)
      CLEAR: begin
        wr_valid_n = 1'b1;
        wr_data_n  = 1'b0;
        wr_addr_n  = clr_addr;
        if (hs) begin
          if (clr_addr == LAST_ADDR) begin
            // Counts are resynchronised here so motion during the sweep is dropped.
            prev_x_n  = x_count;
            prev_y_n  = y_count;
            state_n   = PLOT;
            wr_data_n = 1'b1;
            wr_addr_n = pix_addr(cursor_x, cursor_y);
          end else begin
            clr_addr_n = clr_addr + 1'b1;
            wr_addr_n  = clr_addr + 1'b1;
          end
        end
      end
      PLOT: begin
        if (clear_req)
          clr_pend_n = 1'b1;
        if (hs) begin
          if (clr_pend || clear_req) begin
            clr_pend_n = 1'b0;
            clr_addr_n = '0;
            state_n    = CLEAR;
            wr_valid_n = 1'b1;
            wr_addr_n  = '0;
            wr_data_n  = 1'b0;
          end else begin
            state_n    = IDLE;
            wr_valid_n = 1'b0;
          end
        end
      end
      IDLE: begin
        wr_valid_n = 1'b0;
        if (clear_req) begin
          clr_addr_n = '0;
          state_n    = CLEAR;
          wr_valid_n = 1'b1;
          wr_addr_n  = '0;
          wr_data_n  = 1'b0;
        end else if (dx != 0 || dy != 0) begin
          prev_x_n   = x_count;
          prev_y_n   = y_count;
          cursor_x_n = nx_x;
          cursor_y_n = nx_y;
          state_n    = PLOT;
          wr_valid_n = 1'b1;
          wr_data_n  = 1'b1;
          wr_addr_n  = pix_addr(nx_x, nx_y);
        end
      end
      default: state_n = CLEAR;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      prev_x     <= '0;
      prev_y     <= '0;
      cursor_x   <= X_CENTRE;
      cursor_y   <= Y_CENTRE;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 1'b0;
      clr_pend   <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_n;
      clr_addr   <= clr_addr_n;
      prev_x     <= prev_x_n;
      prev_y     <= prev_y_n;
      cursor_x   <= cursor_x_n;
      cursor_y   <= cursor_y_n;
      wr_valid_q <= wr_valid_n;
      wr_addr_q  <= wr_addr_n;
      wr_data_q  <= wr_data_n;
      clr_pend   <= clr_pend_n;
      busy       <= busy_n;
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;

endmodule

// File: tb/tb_etch_cursor_plotter.sv
// Directed bench for etch_cursor_plotter: clear sweeps, motion, wrap, clamp,
// write-port stalls, deferred and idle clear requests, mid-operation reset.
module tb_etch_cursor_plotter;
  import etch_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [COUNT_W-1:0] x_count, y_count;
  logic               clear_req;
  logic [X_W-1:0]     cursor_x;
  logic [Y_W-1:0]     cursor_y;
  logic               busy;
  state_t             dut_state;

  int n_checks = 0;
  int n_fails  = 0;

  etch_cursor_plotter_if wif();

  etch_cursor_plotter dut (
    .clk(clk), .rst(rst), .x_count(x_count), .y_count(y_count),
    .clear_req(clear_req), .wr(wif), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .busy(busy), .state(dut_state)
  );

  always #5 clk = ~clk;

  // Runs a full blank sweep starting at the current negedge, then checks the
  // cursor plot that follows it and the return to IDLE.
  task automatic run_sweep(input logic [ADDR_W-1:0] exp_plot, input int pulse_at);
    int n = 0;
    int c = 0;
    while (n < NPIX && c < 25000) begin
      if (wif.wr_valid) begin
        n_checks++;
        if (wif.wr_addr !== ADDR_W'(n) || wif.wr_data !== 1'b0 || busy !== 1'b1) begin
          n_fails++;
          $display("FAIL sweep_write %0d: addr=%0d data=%b busy=%b, required addr=%0d data=0 busy=1",
                   n, wif.wr_addr, wif.wr_data, busy, n);
        end
        n++;
      end
      clear_req = (pulse_at >= 0 && n == pulse_at);
      @(negedge clk);
      c++;
    end
    clear_req = 1'b0;
    n_checks++;
    if (n != NPIX) begin
      n_fails++;
      $display("FAIL sweep_count: got %0d writes, required %0d", n, NPIX);
    end
    n_checks++;
    if (wif.wr_valid !== 1'b1 || wif.wr_addr !== exp_plot || wif.wr_data !== 1'b1 || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL post_sweep_plot: valid=%b addr=%0d data=%b busy=%b, required 1/%0d/1/1",
               wif.wr_valid, wif.wr_addr, wif.wr_data, busy, exp_plot);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wif.wr_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL post_sweep_idle: busy=%b valid=%b, required 0/0", busy, wif.wr_valid);
    end
  endtask

  // Applies new counts in IDLE, checks the plot one cycle later, then IDLE.
  task automatic plot_step(input logic [7:0] nx, input logic [7:0] ny,
                           input logic [X_W-1:0] ex, input logic [Y_W-1:0] ey,
                           input logic [ADDR_W-1:0] ea, input string name);
    x_count = nx;
    y_count = ny;
    @(negedge clk);
    n_checks++;
    if (cursor_x !== ex || cursor_y !== ey || wif.wr_valid !== 1'b1 ||
        wif.wr_addr !== ea || wif.wr_data !== 1'b1) begin
      n_fails++;
      $display("FAIL %s: cursor=(%0d,%0d) valid=%b addr=%0d data=%b, required (%0d,%0d) 1 %0d 1",
               name, cursor_x, cursor_y, wif.wr_valid, wif.wr_addr, wif.wr_data, ex, ey, ea);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wif.wr_valid !== 1'b0) begin
      n_fails++;
      $display("FAIL %s_idle: busy=%b valid=%b, required 0/0", name, busy, wif.wr_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x_count = '0;
    y_count = '0;
    clear_req = 1'b0;
    wif.wr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (wif.wr_valid !== 1'b0 || wif.wr_addr !== '0 || wif.wr_data !== 1'b0 ||
        busy !== 1'b1 || cursor_x !== 8'd80 || cursor_y !== 7'd60) begin
      n_fails++;
      $display("FAIL reset_values: valid=%b addr=%0d data=%b busy=%b cursor=(%0d,%0d), required 0/0/0/1 (80,60)",
               wif.wr_valid, wif.wr_addr, wif.wr_data, busy, cursor_x, cursor_y);
    end
  endtask

  task automatic test_power_up_clear();
    rst = 1'b0;
    @(negedge clk);
    // A clear request mid-sweep must not restart the sweep.
    run_sweep(15'd9680, 5000);
  endtask

  task automatic test_motion_and_wrap();
    plot_step(8'd1,   8'd0, 8'd81, 7'd60, 15'd9681, "move_right");
    plot_step(8'd0,   8'd0, 8'd80, 7'd60, 15'd9680, "move_left");
    plot_step(8'd255, 8'd0, 8'd79, 7'd60, 15'd9679, "wrap_0_to_255");
    plot_step(8'd0,   8'd0, 8'd80, 7'd60, 15'd9680, "wrap_255_to_0");
  endtask

  task automatic test_clamp();
    plot_step(8'd79,  8'd0,   8'd159, 7'd60,  15'd9759,  "to_right_edge");
    plot_step(8'd84,  8'd0,   8'd159, 7'd60,  15'd9759,  "clamp_right");
    plot_step(8'd212, 8'd0,   8'd31,  7'd60,  15'd9631,  "step_minus_128");
    plot_step(8'd84,  8'd0,   8'd0,   7'd60,  15'd9600,  "clamp_left");
    plot_step(8'd164, 8'd0,   8'd80,  7'd60,  15'd9680,  "back_to_centre_x");
    plot_step(8'd164, 8'd100, 8'd80,  7'd119, 15'd19120, "clamp_bottom");
  endtask

  task automatic test_stall_accumulate();
    wif.wr_ready = 1'b0;
    y_count = 8'd41;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (wif.wr_valid !== 1'b1 || wif.wr_addr !== 15'd9680 || wif.wr_data !== 1'b1 || cursor_y !== 7'd60) begin
        n_fails++;
        $display("FAIL stall_hold %0d: valid=%b addr=%0d data=%b y=%0d, required 1/9680/1/60",
                 i, wif.wr_valid, wif.wr_addr, wif.wr_data, cursor_y);
      end
      if (i == 2 || i == 4 || i == 6)
        y_count = y_count + 8'd1;
      @(negedge clk);
    end
    wif.wr_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (wif.wr_valid !== 1'b0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL stall_release_idle: valid=%b busy=%b, required 0/0", wif.wr_valid, busy);
    end
    @(negedge clk);
    n_checks++;
    if (cursor_y !== 7'd63 || wif.wr_valid !== 1'b1 || wif.wr_addr !== 15'd10160) begin
      n_fails++;
      $display("FAIL stall_accumulated: y=%0d valid=%b addr=%0d, required 63/1/10160",
               cursor_y, wif.wr_valid, wif.wr_addr);
    end
    @(negedge clk);
  endtask

  task automatic test_clear_during_plot();
    wif.wr_ready = 1'b0;
    x_count = 8'd165;
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wif.wr_addr !== 15'd10161 || wif.wr_data !== 1'b1 || busy !== 1'b1 || wif.wr_valid !== 1'b1) begin
        n_fails++;
        $display("FAIL pend_hold %0d: valid=%b addr=%0d data=%b busy=%b, required 1/10161/1/1",
                 i, wif.wr_valid, wif.wr_addr, wif.wr_data, busy);
      end
      @(negedge clk);
    end
    wif.wr_ready = 1'b1;
    @(negedge clk);
    run_sweep(15'd10161, -1);
  endtask

  task automatic test_idle_clear_priority();
    clear_req = 1'b1;
    x_count = 8'd166;
    @(negedge clk);
    clear_req = 1'b0;
    n_checks++;
    if (cursor_x !== 8'd81 || wif.wr_valid !== 1'b1 || wif.wr_addr !== '0 || wif.wr_data !== 1'b0) begin
      n_fails++;
      $display("FAIL idle_clear_start: x=%0d valid=%b addr=%0d data=%b, required 81/1/0/0",
               cursor_x, wif.wr_valid, wif.wr_addr, wif.wr_data);
    end
    run_sweep(15'd10161, -1);
  endtask

  task automatic test_reset_mid_plot();
    wif.wr_ready = 1'b0;
    x_count = 8'd170;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (wif.wr_valid !== 1'b0 || wif.wr_addr !== '0 || busy !== 1'b1 ||
        cursor_x !== 8'd80 || cursor_y !== 7'd60) begin
      n_fails++;
      $display("FAIL reset_mid_plot: valid=%b addr=%0d busy=%b cursor=(%0d,%0d), required 0/0/1 (80,60)",
               wif.wr_valid, wif.wr_addr, busy, cursor_x, cursor_y);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_power_up_clear();
    test_motion_and_wrap();
    test_clamp();
    test_stall_accumulate();
    test_clear_during_plot();
    test_idle_clear_priority();
    test_reset_mid_plot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
